// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-path defaults and the inflight response state encoding.
package cpu_pkg;
   localparam int          CPU_ADDR_W   = 32;
   localparam int          CPU_INST_W   = 32;
   localparam logic [31:0] CPU_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] CPU_PC_STEP  = 32'd4;

   typedef enum logic [1:0] {
      INFL_IDLE,
      INFL_PENDING,
      INFL_SQUASHED
   } inflight_e;
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry synchronous prefetch FIFO with push/pop/flush and occupancy.
module fetch_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic [W-1:0]               push_data_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   output logic [W-1:0]               head_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       full_o,
   output logic                       empty_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + CW'(push_i) - CW'(pop_i);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage needs no reset: it is only observed through a non-empty head.
   always_ff @(posedge clk) begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch stage: owns the PC, issues imem reads, buffers words for the decoder.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int                ADDR_W   = CPU_ADDR_W,
   parameter int                INST_W   = CPU_INST_W,
   parameter int                DEPTH    = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = CPU_RESET_PC,
   parameter logic [ADDR_W-1:0] PC_STEP  = CPU_PC_STEP
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_en,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [INST_W-1:0] imem_rdata,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [INST_W-1:0] inst_data,
   output logic [ADDR_W-1:0] inst_pc,
   output logic [ADDR_W-1:0] inst_pc_next
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] infl_pc_q, infl_pc_d;
   inflight_e         infl_q, infl_d, infl_now;

   logic [CW-1:0]            fifo_count;
   logic                     fifo_full, fifo_empty;
   logic [INST_W+ADDR_W-1:0] fifo_head;
   logic                     push, pop, issue;
   logic [CW:0]              demand;

   assign pop = !fifo_empty && inst_ready;

   // A redirect in the arrival cycle turns the pending response into a squashed one.
   assign infl_now = (infl_q == INFL_PENDING && redirect_valid) ? INFL_SQUASHED : infl_q;
   assign push     = (infl_now == INFL_PENDING);

   always_comb begin
      demand = {1'b0, fifo_count} + (CW+1)'(infl_q != INFL_IDLE) - (CW+1)'(pop);
      issue  = !rst && fetch_en && !redirect_valid && (demand < (CW+1)'(DEPTH));

      pc_d      = pc_q;
      infl_pc_d = infl_pc_q;
      infl_d    = issue ? INFL_PENDING : INFL_IDLE;
      if (redirect_valid) begin
         pc_d = redirect_pc;
      end else if (issue) begin
         pc_d      = pc_q + PC_STEP;
         infl_pc_d = pc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q      <= RESET_PC;
         infl_pc_q <= '0;
         infl_q    <= INFL_IDLE;
      end else begin
         pc_q      <= pc_d;
         infl_pc_q <= infl_pc_d;
         infl_q    <= infl_d;
      end
   end

   fetch_fifo #(
      .W     (INST_W + ADDR_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .push_data_i ({imem_rdata, infl_pc_q}),
      .pop_i       (pop),
      .flush_i     (redirect_valid),
      .head_o      (fifo_head),
      .count_o     (fifo_count),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   assert property (@(posedge clk) disable iff (rst) !(push && fifo_full && !pop));

   assign imem_req     = issue;
   assign imem_addr    = pc_q;
   assign inst_valid   = !fifo_empty;
   assign inst_data    = fifo_empty ? '0 : fifo_head[INST_W+ADDR_W-1:ADDR_W];
   assign inst_pc      = fifo_empty ? '0 : fifo_head[ADDR_W-1:0];
   assign inst_pc_next = fifo_empty ? '0 : fifo_head[ADDR_W-1:0] + PC_STEP;
endmodule
